// File: rtl/g18_flash_reader_pkg.sv
// rtl/g18_flash_reader_pkg.sv - shared types and constants for the g18 BPI flash reader
// Contents:
//   g18_state_t           reader FSM states
//   G18_ADR_W, G18_DAT_W  flash word-address and data widths
//   BOOT_BASE, DIAG_BASE  flash word addresses of the boot image and the diag ROM
package g18_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_HI,
    RD_LO,
    RESP
  } g18_state_t;

  localparam int G18_ADR_W = 23;
  localparam int G18_DAT_W = 16;

  localparam logic [G18_ADR_W-1:0] BOOT_BASE = 23'h000000;
  localparam logic [G18_ADR_W-1:0] DIAG_BASE = 23'h400000;

endpackage

// File: rtl/g18_flash_reader.sv
// rtl/g18_flash_reader.sv - Wishbone classic read-only slave for the 16-bit g18 BPI flash
// Ports:
//   sys_clk_i, sys_rst_ni   clock, asynchronous active-low reset
//   wb_adr_i                byte address, bits [ADR_W:2] select a 32-bit flash word pair
//   wb_dat_o                read data, big-endian assembly of two 16-bit flash words
//   wb_sel_i                byte selects, [3:2] fetch the even word, [1:0] the odd word
//   wb_we_i                 write request, always answered with wb_err_o
//   wb_cyc_i, wb_stb_i      cycle / strobe
//   wb_ack_o, wb_err_o      one-cycle completion pulses
//   g18_adr_o               registered flash word address
//   g18_wen_o               flash output enable, high while a flash phase is running
//   g18_dat_i               flash read data
module g18_flash_reader
  import g18_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADR_W       = G18_ADR_W
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_ni,
  input  logic [31:0]      wb_adr_i,
  output logic [31:0]      wb_dat_o,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic [ADR_W-1:0] g18_adr_o,
  output logic             g18_wen_o,
  input  logic [15:0]      g18_dat_i
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  g18_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             lo_q, lo_d;   // low half still to be fetched after RD_HI
  logic             err_q, err_d; // RESP answers with err instead of ack

  // Address bits outside the decoded window alias and are deliberately dropped.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:ADR_W+1], wb_adr_i[1:0]};

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      lo_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    lo_d    = lo_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (wb_we_i) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d = 1'b0;
            // Address and selects are captured here; the phases never look at
            // the bus inputs again.
            lo_d  = |wb_sel_i[1:0];
            if (|wb_sel_i[3:2]) begin
              state_d = RD_HI;
              adr_d   = {wb_adr_i[ADR_W:2], 1'b0};
              cnt_d   = CNT_LOAD;
            end else if (|wb_sel_i[1:0]) begin
              state_d = RD_LO;
              adr_d   = {wb_adr_i[ADR_W:2], 1'b1};
              cnt_d   = CNT_LOAD;
            end else begin
              state_d = RESP;
            end
          end
        end
      end

      RD_HI: begin
        if (cnt_q == '0) begin
          dat_d[31:16] = g18_dat_i;
          if (lo_q) begin
            state_d  = RD_LO;
            adr_d[0] = 1'b1;
            cnt_d    = CNT_LOAD;
          end else begin
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RD_LO: begin
        if (cnt_q == '0) begin
          dat_d[15:0] = g18_dat_i;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wb_dat_o  = dat_q;
  assign g18_adr_o = adr_q;
  assign wb_ack_o  = (state_q == RESP) && !err_q;
  assign wb_err_o  = (state_q == RESP) && err_q;
  assign g18_wen_o = (state_q == RD_HI) || (state_q == RD_LO);

endmodule

// File: tb/tb_g18_flash_reader.sv
// tb/tb_g18_flash_reader.sv - scoreboard bench for g18_flash_reader at WAIT_CYCLES 2 and 4
module tb_g18_flash_reader;
  import g18_pkg::*;

  typedef struct {
    int          d;
    bit          is_err;
    logic [31:0] dat;
    int          start;
    int          lat;
    int          wen_cyc;
    logic [22:0] adr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] wb_adr [2];
  logic [31:0] wb_dat [2];
  logic [3:0]  wb_sel [2];
  logic        wb_we  [2];
  logic        wb_cyc [2];
  logic        wb_stb [2];
  logic        wb_ack [2];
  logic        wb_err [2];
  logic [22:0] g18_adr [2];
  logic        g18_wen [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_cnt = 0;
  exp_t        exp_q[$];
  logic [31:0] model_dat [2];
  logic [22:0] model_adr [2];
  int          wen_cnt [2];
  bit          resp_prev [2];

  function automatic logic [15:0] flash_word(input logic [22:0] a);
    case (a)
      23'h000000: return 16'h1234;
      23'h000001: return 16'h5678;
      23'h400001: return 16'hBEEF;
      default:    return a[15:0] ^ {a[22:16], 9'h0A5} ^ 16'h3C5A;
    endcase
  endfunction

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] fl_dat;
    g18_flash_reader #(.WAIT_CYCLES(g == 0 ? 2 : 4), .ADR_W(23)) u_dut (
      .sys_clk_i  (clk),
      .sys_rst_ni (rst_n),
      .wb_adr_i   (wb_adr[g]),
      .wb_dat_o   (wb_dat[g]),
      .wb_sel_i   (wb_sel[g]),
      .wb_we_i    (wb_we[g]),
      .wb_cyc_i   (wb_cyc[g]),
      .wb_stb_i   (wb_stb[g]),
      .wb_ack_o   (wb_ack[g]),
      .wb_err_o   (wb_err[g]),
      .g18_adr_o  (g18_adr[g]),
      .g18_wen_o  (g18_wen[g]),
      .g18_dat_i  (fl_dat)
    );
    // Registered flash: data for the current address appears one edge later.
    always @(posedge clk) fl_dat <= flash_word(g18_adr[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  // Reference model: a Wishbone word is two big-endian flash words; each
  // selected half costs one flash phase of WAIT_CYCLES, plus one response cycle.
  task automatic push_exp(input int d, input bit we, input logic [31:0] adr,
                          input logic [3:0] sel, input int start);
    exp_t        e;
    logic [22:0] base;
    int          phases;
    base   = {adr[23:2], 1'b0};
    phases = 0;
    e.d      = d;
    e.is_err = we;
    e.start  = start;
    if (!we) begin
      if (sel[3:2] != 2'b00) begin
        model_dat[d][31:16] = flash_word(base);
        model_adr[d]        = base;
        phases++;
      end
      if (sel[1:0] != 2'b00) begin
        model_dat[d][15:0] = flash_word(base | 23'h1);
        model_adr[d]       = base | 23'h1;
        phases++;
      end
    end
    e.dat     = model_dat[d];
    e.adr     = model_adr[d];
    e.lat     = phases * wc(d) + 1;
    e.wen_cyc = phases * wc(d);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        wen_cnt[d]   = 0;
        resp_prev[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (g18_wen[d]) wen_cnt[d]++;
        if (wb_ack[d] || wb_err[d]) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp dut%0d: got ack=%0b err=%0b expected none", d, wb_ack[d], wb_err[d]);
          end else begin
            e = exp_q.pop_front();
            chk("resp_dut", d, d, e.d);
            chk("err_flag", d, wb_err[d], e.is_err);
            chk("ack_flag", d, wb_ack[d], !e.is_err);
            chk("rd_data", d, wb_dat[d], e.dat);
            chk("latency", d, cyc_cnt - e.start, e.lat);
            chk("wen_cycles", d, wen_cnt[d], e.wen_cyc);
            chk("flash_adr", d, g18_adr[d], e.adr);
            chk("pulse_width", d, resp_prev[d], 0);
          end
          wen_cnt[d] = 0;
        end
        resp_prev[d] = wb_ack[d] || wb_err[d];
      end
    end
  end

  task automatic wait_resp(input int d, input bit scramble, output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wb_ack[d] || wb_err[d]) begin
        got = 1'b1;
        break;
      end
      if (scramble) begin
        // The slave must ignore the bus once the transaction has started.
        wb_adr[d] = $urandom;
        wb_sel[d] = 4'($urandom);
        wb_we[d]  = 1'($urandom);
        wb_cyc[d] = 1'($urandom);
      end
    end
    if (!got) chk("resp_timeout", d, 0, 1);
  endtask

  task automatic xact(input int d, input bit we, input logic [31:0] adr, input logic [3:0] sel);
    bit got;
    @(negedge clk);
    push_exp(d, we, adr, sel, cyc_cnt);
    wb_adr[d] = adr;
    wb_sel[d] = sel;
    wb_we[d]  = we;
    wb_cyc[d] = 1'b1;
    wb_stb[d] = 1'b1;
    wait_resp(d, 1'b1, got);
    wb_cyc[d] = 1'b0;
    wb_stb[d] = 1'b0;
    wb_we[d]  = 1'b0;
  endtask

  task automatic b2b(input int d);
    logic [31:0] a [3];
    bit          got;
    a[0] = 32'h0;
    a[1] = 32'h4;
    a[2] = 32'h8;
    @(negedge clk);
    push_exp(d, 1'b0, a[0], 4'hF, cyc_cnt);
    wb_adr[d] = a[0];
    wb_sel[d] = 4'hF;
    wb_we[d]  = 1'b0;
    wb_cyc[d] = 1'b1;
    wb_stb[d] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_resp(d, 1'b0, got);
      if (i < 2) begin
        // stb stays high: IDLE picks this up on the edge after RESP.
        push_exp(d, 1'b0, a[i+1], 4'hF, cyc_cnt + 1);
        wb_adr[d] = a[i+1];
      end
    end
    wb_cyc[d] = 1'b0;
    wb_stb[d] = 1'b0;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wb_adr[d] = '0; wb_sel[d] = '0; wb_we[d] = 1'b0;
      wb_cyc[d] = 1'b0; wb_stb[d] = 1'b0;
      model_dat[d] = '0; model_adr[d] = '0;
    end

    // Reset held with random bus activity.
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        wb_adr[d] = $urandom; wb_sel[d] = 4'($urandom); wb_we[d] = 1'($urandom);
        wb_cyc[d] = 1'($urandom); wb_stb[d] = 1'($urandom);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_ack", d, wb_ack[d], 0);
        chk("rst_err", d, wb_err[d], 0);
        chk("rst_wen", d, g18_wen[d], 0);
        chk("rst_adr", d, g18_adr[d], 0);
        chk("rst_dat", d, wb_dat[d], 0);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      wb_cyc[d] = 1'b0; wb_stb[d] = 1'b0; wb_we[d] = 1'b0;
    end
    rst_n = 1'b1;

    xact(0, 1'b0, 32'h0000_0000, 4'hF);
    xact(0, 1'b0, 32'h0080_0000, 4'h3);
    xact(0, 1'b0, 32'h0080_0000, 4'hC);
    xact(0, 1'b1, 32'h0000_0040, 4'hF);
    xact(0, 1'b0, 32'h0000_0100, 4'h0);
    xact(0, 1'b0, 32'hFF80_0004, 4'hF);

    // Reset one cycle into the low phase of a full read.
    @(negedge clk);
    wb_adr[0] = 32'h10; wb_sel[0] = 4'hF; wb_we[0] = 1'b0;
    wb_cyc[0] = 1'b1; wb_stb[0] = 1'b1;
    repeat (3) @(negedge clk);
    wb_cyc[0] = 1'b0; wb_stb[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wen", 0, g18_wen[0], 0);
    chk("arst_adr", 0, g18_adr[0], 0);
    chk("arst_dat", 0, wb_dat[0], 0);
    chk("arst_ack", 0, wb_ack[0], 0);
    for (int d = 0; d < 2; d++) begin
      model_dat[d] = '0;
      model_adr[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (wb_ack[0] || wb_err[0]) seen = 1'b1;
    end
    chk("arst_no_ack", 0, seen, 0);
    xact(0, 1'b0, 32'h0000_0010, 4'hF);

    for (int i = 0; i < 40; i++)
      xact(0, ($urandom_range(0, 4) == 0), $urandom, 4'($urandom));

    b2b(1);
    for (int i = 0; i < 15; i++)
      xact(1, ($urandom_range(0, 4) == 0), $urandom, 4'($urandom));

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 0, exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
